// File: rtl/memtest_reporter_if.sv
// Bundle between the memory tester and its UART status reporter: the live
// counters plus an on-demand request in, the serial line and status out.
interface memtest_reporter_if;
  logic [31:0] passcount;
  logic [31:0] failcount;
  logic        report_req;
  logic        uart_txd;
  logic        busy;
  logic        fail_seen;
  logic [15:0] lines_sent;

  modport master (
    output passcount, failcount, report_req,
    input  uart_txd, busy, fail_seen, lines_sent
  );

  modport slave (
    input  passcount, failcount, report_req,
    output uart_txd, busy, fail_seen, lines_sent
  );
endinterface

// File: rtl/memtest_reporter.sv
// Sends "P:xxxxxxxx F:xxxxxxxx\r\n" over an 8N1 UART whenever the tester's
// pass/fail counters change or a report is requested.
module memtest_reporter #(
  parameter int CLK_DIV        = 434,
  parameter int STARTUP_REPORT = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  memtest_reporter_if.slave bus
);

  typedef enum logic [2:0] {IDLE, LOAD, START, DATA, STOP, DONE} state_t;

  localparam logic [15:0] DIV_M1       = 16'(CLK_DIV - 1);
  localparam logic        STARTUP_PEND = (STARTUP_REPORT != 0);
  localparam logic [4:0]  LAST_BYTE    = 5'd22;

  state_t      state, state_nxt;
  logic        started, pending, trigger;
  logic [4:0]  idx;
  logic [2:0]  bit_idx;
  logic [15:0] div_cnt;
  logic [7:0]  shreg;
  logic [31:0] snap_pass, snap_fail, last_pass, last_fail;
  logic        fail_seen;
  logic [15:0] lines_sent;
  logic        txd, busy;
  logic        bit_end;

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h37 + {4'h0, n});
  endfunction

  function automatic logic [7:0] line_byte(input logic [4:0]  i,
                                           input logic [31:0] p,
                                           input logic [31:0] f);
    logic [4:0] sh;
    logic [7:0] b;
    sh = 5'd0;
    b  = 8'h0A;
    if (i == 5'd0)                      b = 8'h50;
    else if (i == 5'd1 || i == 5'd12)   b = 8'h3A;
    else if (i <= 5'd9) begin
      sh = (5'd9 - i) << 2;
      b  = hex_char(p[sh +: 4]);
    end
    else if (i == 5'd10)                b = 8'h20;
    else if (i == 5'd11)                b = 8'h46;
    else if (i <= 5'd20) begin
      sh = (5'd20 - i) << 2;
      b  = hex_char(f[sh +: 4]);
    end
    else if (i == 5'd21)                b = 8'h0D;
    return b;
  endfunction

  assign bit_end = (div_cnt == 16'd0);
  // The first clock after reset release only arms the startup request.
  assign trigger = started && ((bus.passcount != last_pass) ||
                               (bus.failcount != last_fail) ||
                               pending || bus.report_req);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    txd       = 1'b1;
    busy      = 1'b1;
    case (state)
      IDLE:  begin
        busy = 1'b0;
        if (trigger) state_nxt = LOAD;
      end
      LOAD:  state_nxt = START;
      START: begin
        txd = 1'b0;
        if (bit_end) state_nxt = DATA;
      end
      DATA:  begin
        txd = shreg[0];
        if (bit_end && bit_idx == 3'd7) state_nxt = STOP;
      end
      STOP:  if (bit_end) state_nxt = (idx < LAST_BYTE) ? LOAD : DONE;
      DONE:  state_nxt = IDLE;
      default: begin
        busy      = 1'b0;
        state_nxt = IDLE;
      end
    endcase
    if (idx > LAST_BYTE) state_nxt = IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      started    <= 1'b0;
      pending    <= 1'b0;
      idx        <= 5'd0;
      bit_idx    <= 3'd0;
      div_cnt    <= 16'd0;
      shreg      <= 8'hFF;
      snap_pass  <= 32'd0;
      snap_fail  <= 32'd0;
      last_pass  <= 32'd0;
      last_fail  <= 32'd0;
      fail_seen  <= 1'b0;
      lines_sent <= 16'd0;
    end else begin
      if (!started) begin
        started <= 1'b1;
        pending <= STARTUP_PEND | bus.report_req;
      end else if (state == IDLE && trigger) begin
        pending <= 1'b0;
      end else if (bus.report_req) begin
        pending <= 1'b1;
      end

      case (state)
        IDLE: if (trigger) begin
          snap_pass <= bus.passcount;
          snap_fail <= bus.failcount;
          last_pass <= bus.passcount;
          last_fail <= bus.failcount;
          if (bus.failcount != 32'd0) fail_seen <= 1'b1;
        end
        LOAD: begin
          shreg   <= line_byte(idx, snap_pass, snap_fail);
          div_cnt <= DIV_M1;
        end
        START: begin
          if (bit_end) begin
            div_cnt <= DIV_M1;
            bit_idx <= 3'd0;
          end else begin
            div_cnt <= div_cnt - 16'd1;
          end
        end
        DATA: begin
          if (bit_end) begin
            div_cnt <= DIV_M1;
            shreg   <= {1'b1, shreg[7:1]};
            bit_idx <= bit_idx + 3'd1;
          end else begin
            div_cnt <= div_cnt - 16'd1;
          end
        end
        STOP: begin
          if (bit_end) begin
            div_cnt <= 16'd0;
            if (idx < LAST_BYTE) idx <= idx + 5'd1;
          end else begin
            div_cnt <= div_cnt - 16'd1;
          end
        end
        DONE: begin
          lines_sent <= lines_sent + 16'd1;
          idx        <= 5'd0;
        end
        default: idx <= 5'd0;
      endcase

      if (idx > LAST_BYTE) idx <= 5'd0;
    end
  end

  assign bus.uart_txd   = txd;
  assign bus.busy       = busy;
  assign bus.fail_seen  = fail_seen;
  assign bus.lines_sent = lines_sent;

endmodule
